// File: rtl/namco_cpu_ctrl_latch_n.sv
// CPU control latch bank for Namco multi-CPU boards: per-CPU IRQ latches fed by VBLK,
// per-CPU NMI latches fed by a periodic timer, and a shared sub-CPU hold-reset.
module namco_cpu_ctrl_latch_n #(
  parameter int              NCPU        = 3,
  parameter int              ADW         = 4,
  parameter int              TIMER_DIV   = 16,
  parameter int              TIMER_FLOW  = 12500,
  parameter int              TIMER_PULSE = 200,
  parameter bit              IRQ_EDGE    = 1'b0,
  parameter logic [NCPU-1:0] NMI_POL     = '0
) (
  input  logic            CL,
  input  logic            RESET,
  input  logic [ADW-1:0]  AD,
  input  logic            WR,
  input  logic            DI,
  input  logic            VBLK,
  output logic [NCPU-1:0] RSTS,
  output logic [NCPU-1:0] IRQS,
  output logic [NCPU-1:0] NMIS,
  output logic            TICK
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam int CW = $clog2(TIMER_FLOW + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TIMER_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMER_FLOW);
  localparam logic [CW-1:0] H_START  = CW'(TIMER_FLOW - TIMER_PULSE);

  logic [NCPU-1:0] irqen_q, irqen_d;
  logic [NCPU-1:0] irqlc_q, irqlc_d;
  logic [NCPU-1:0] nmien_q, nmien_d;
  logic [NCPU-1:0] nmilc_q, nmilc_d;
  logic            subrst_q, subrst_d;
  logic            pvblk_q;
  logic            ph_q;
  logic            tick_q, tick_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            tick_en;
  logic            h_win;
  logic            irq_set;
  logic            nmi_new;

  always_comb begin
    irqen_d  = irqen_q;
    irqlc_d  = irqlc_q;
    nmien_d  = nmien_q;
    nmilc_d  = nmilc_q;
    subrst_d = subrst_q;
    nmi_new  = 1'b0;

    for (int i = 0; i < NCPU; i++) begin
      if (WR && (AD == ADW'(i))) begin
        irqen_d[i] = DI;
        if (!DI) irqlc_d[i] = 1'b0;
      end
      if (WR && (AD == ADW'(NCPU + i))) begin
        nmi_new    = DI ^ NMI_POL[i];
        nmien_d[i] = nmi_new;
        if (!nmi_new) nmilc_d[i] = 1'b0;
      end
    end
    if (WR && (AD == ADW'(2 * NCPU))) subrst_d = ~DI;

    // Set sources are applied after the clearing writes so a collision leaves the latch set.
    irq_set = IRQ_EDGE ? (VBLK & ~pvblk_q) : VBLK;
    if (irq_set) irqlc_d = '1;
    if (tick_q)  nmilc_d = '1;
  end

  always_comb begin
    tick_en = (pre_q == PRE_LAST);
    pre_d   = tick_en ? '0 : pre_q + 1'b1;
    cnt_d   = cnt_q;
    if (tick_en) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    h_win   = (cnt_q >= H_START);
    tick_d  = h_win & ~ph_q;
  end

  always_ff @(posedge CL) begin
    if (RESET) begin
      irqen_q  <= '0;
      irqlc_q  <= '0;
      nmien_q  <= '0;
      nmilc_q  <= '0;
      subrst_q <= 1'b1;
      pvblk_q  <= 1'b0;
      ph_q     <= 1'b0;
      tick_q   <= 1'b0;
      pre_q    <= '0;
      cnt_q    <= '0;
    end else begin
      irqen_q  <= irqen_d;
      irqlc_q  <= irqlc_d;
      nmien_q  <= nmien_d;
      nmilc_q  <= nmilc_d;
      subrst_q <= subrst_d;
      pvblk_q  <= VBLK;
      ph_q     <= h_win;
      tick_q   <= tick_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
    end
  end

  assign RSTS = {{(NCPU-1){subrst_q}}, RESET};
  assign IRQS = irqen_q & irqlc_q;
  assign NMIS = nmien_q & nmilc_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_namco_cpu_ctrl_latch_n.sv
// Scoreboarded bench: one level-mode and one edge-mode latch bank share all inputs;
// expected output values and expected TICK cycles are queued and checked by a monitor.
module tb_namco_cpu_ctrl_latch_n;

  logic       CL = 1'b0;
  logic       RESET;
  logic [3:0] AD;
  logic       WR, DI, VBLK;
  logic [2:0] rsts0, irqs0, nmis0, rsts1, irqs1, nmis1;
  logic       tick0, tick1;

  namco_cpu_ctrl_latch_n #(
    .NCPU(3), .ADW(4), .TIMER_DIV(2), .TIMER_FLOW(10), .TIMER_PULSE(2),
    .IRQ_EDGE(1'b0), .NMI_POL(3'b100)
  ) dut_lvl (
    .CL(CL), .RESET(RESET), .AD(AD), .WR(WR), .DI(DI), .VBLK(VBLK),
    .RSTS(rsts0), .IRQS(irqs0), .NMIS(nmis0), .TICK(tick0)
  );

  namco_cpu_ctrl_latch_n #(
    .NCPU(3), .ADW(4), .TIMER_DIV(2), .TIMER_FLOW(10), .TIMER_PULSE(2),
    .IRQ_EDGE(1'b1), .NMI_POL(3'b100)
  ) dut_edg (
    .CL(CL), .RESET(RESET), .AD(AD), .WR(WR), .DI(DI), .VBLK(VBLK),
    .RSTS(rsts1), .IRQS(irqs1), .NMIS(nmis1), .TICK(tick1)
  );

  always #5 CL = ~CL;

  int cyc = 0;
  always @(posedge CL) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         sig;
    logic [2:0] val;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   tickq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam int S_RST0 = 0, S_IRQ0 = 1, S_NMI0 = 2, S_TCK0 = 3;
  localparam int S_RST1 = 4, S_IRQ1 = 5, S_NMI1 = 6;

  function automatic logic [2:0] probe(int sig);
    case (sig)
      S_RST0:  return rsts0;
      S_IRQ0:  return irqs0;
      S_NMI0:  return nmis0;
      S_TCK0:  return {2'b00, tick0};
      S_RST1:  return rsts1;
      S_IRQ1:  return irqs1;
      default: return nmis1;
    endcase
  endfunction

  task automatic expect_now(int sig, logic [2:0] val, string name);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge CL);
    #1;
  endtask

  task automatic step_until(int n);
    while (cyc < n) step();
  endtask

  task automatic mid();
    @(negedge CL);
    #1;
  endtask

  task automatic wr(int a, logic d);
    AD = 4'(a);
    DI = d;
    WR = 1'b1;
    step();
    WR = 1'b0;
  endtask

  task automatic expect_reset_state(string tag);
    expect_now(S_RST0, 3'b111, {tag, "_rsts_lvl"});
    expect_now(S_IRQ0, 3'b000, {tag, "_irqs_lvl"});
    expect_now(S_NMI0, 3'b000, {tag, "_nmis_lvl"});
    expect_now(S_RST1, 3'b111, {tag, "_rsts_edg"});
    expect_now(S_IRQ1, 3'b000, {tag, "_irqs_edg"});
    expect_now(S_NMI1, 3'b000, {tag, "_nmis_edg"});
  endtask

  // Monitor: compares queued expectations on the falling edge, and every observed TICK
  // against the next expected tick cycle.
  always @(negedge CL) begin
    exp_t e;
    int   t;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_chk++;
      if (probe(e.sig) !== e.val) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got %b, expected %b", e.name, cyc, probe(e.sig), e.val);
      end
    end
    if (tick0 === 1'b1 && tickq.size() > 0) begin
      t = tickq.pop_front();
      n_chk++;
      if (cyc != t) begin
        n_fail++;
        $display("FAIL tick_time: TICK seen at cyc %0d, expected at cyc %0d", cyc, t);
      end
    end
  end

  initial begin
    RESET = 1'b1;
    AD    = '0;
    WR    = 1'b0;
    DI    = 1'b0;
    VBLK  = 1'b0;

    step();                           // cyc 1
    expect_reset_state("rst_a");
    step();                           // cyc 2, last reset edge
    expect_reset_state("rst_b");
    mid();
    RESET = 1'b0;
    tickq.push_back(19);              // 2 + (10-2)*2 + 1
    tickq.push_back(41);
    tickq.push_back(63);

    step();                           // cyc 3
    expect_now(S_RST0, 3'b110, "release_rsts");
    expect_now(S_IRQ0, 3'b000, "release_irqs");
    wr(6, 1'b1);                      // cyc 4
    expect_now(S_RST0, 3'b000, "subrst_off");
    expect_now(S_RST1, 3'b000, "subrst_off_edg");
    wr(6, 1'b0);                      // cyc 5
    expect_now(S_RST0, 3'b110, "subrst_on");
    wr(5, 1'b0);                      // cyc 6
    expect_now(S_NMI0, 3'b000, "nmi_en_no_tick");

    wr(0, 1'b1);                      // cyc 7
    wr(1, 1'b1);                      // cyc 8
    expect_now(S_IRQ0, 3'b000, "irq_en_no_vblk");
    VBLK = 1'b1;
    step();                           // cyc 9
    expect_now(S_IRQ0, 3'b011, "vblk_set_lvl");
    expect_now(S_IRQ1, 3'b011, "vblk_set_edg");
    VBLK = 1'b0;
    step();                           // cyc 10
    expect_now(S_IRQ0, 3'b011, "irq_held");
    wr(0, 1'b0);                      // cyc 11
    expect_now(S_IRQ0, 3'b010, "irq0_clear");
    wr(0, 1'b1);                      // cyc 12
    expect_now(S_IRQ0, 3'b010, "irq0_reen_no_vblk");

    VBLK = 1'b1;
    wr(2, 1'b0);                      // cyc 13
    VBLK = 1'b0;
    expect_now(S_IRQ0, 3'b011, "collide_lvl");
    expect_now(S_IRQ1, 3'b011, "collide_edg");
    wr(2, 1'b1);                      // cyc 14
    expect_now(S_IRQ0, 3'b111, "pending_lc2_lvl");
    expect_now(S_IRQ1, 3'b111, "pending_lc2_edg");

    VBLK = 1'b1;                      // held high for edges 15..64
    step();                           // cyc 15
    expect_now(S_IRQ0, 3'b111, "vblk_long_start");
    step_until(19);
    expect_now(S_TCK0, 3'b001, "tick_first");
    expect_now(S_NMI0, 3'b000, "nmi_before_latch");
    step();                           // cyc 20
    expect_now(S_TCK0, 3'b000, "tick_one_cycle");
    expect_now(S_NMI0, 3'b100, "nmi2_rise");
    wr(0, 1'b0);                      // cyc 21
    expect_now(S_IRQ0, 3'b110, "vblk_hi_clear_lvl");
    expect_now(S_IRQ1, 3'b110, "vblk_hi_clear_edg");
    wr(0, 1'b1);                      // cyc 22
    expect_now(S_IRQ0, 3'b111, "level_resets_lc0");
    expect_now(S_IRQ1, 3'b110, "edge_no_reset_lc0");
    step_until(40);
    expect_now(S_IRQ1, 3'b110, "edge_still_clear");
    step_until(42);
    expect_now(S_TCK0, 3'b000, "tick2_one_cycle");
    wr(5, 1'b1);                      // cyc 43
    expect_now(S_NMI0, 3'b000, "nmi2_disable");
    step_until(64);
    expect_now(S_NMI0, 3'b000, "nmi2_disabled_tick");
    VBLK = 1'b0;
    step();                           // cyc 65
    expect_now(S_IRQ1, 3'b110, "edge_after_fall");
    VBLK = 1'b1;
    step();                           // cyc 66
    VBLK = 1'b0;
    expect_now(S_IRQ1, 3'b111, "edge_new_rise");
    wr(5, 1'b0);                      // cyc 67
    expect_now(S_NMI0, 3'b100, "nmi_pending_on_enable");

    // Period counter is 7 after edge 82; reset sampled at edge 83 restarts the timer.
    step_until(82);
    RESET = 1'b1;
    step();                           // cyc 83
    expect_reset_state("rst_mid");
    tickq.push_back(100);             // 83 + (10-2)*2 + 1
    mid();
    RESET = 1'b0;
    step();                           // cyc 84
    expect_now(S_RST0, 3'b110, "mid_release_rsts");
    wr(0, 1'b1);                      // cyc 85
    expect_now(S_IRQ0, 3'b000, "mid_irqlc_cleared");
    expect_now(S_IRQ1, 3'b000, "mid_irqlc_cleared_edg");
    wr(5, 1'b0);                      // cyc 86
    expect_now(S_NMI0, 3'b000, "mid_nmilc_cleared");
    step_until(99);
    expect_now(S_TCK0, 3'b000, "mid_tick_not_early");
    step();                           // cyc 100
    expect_now(S_TCK0, 3'b001, "mid_tick_first");
    step();                           // cyc 101
    expect_now(S_NMI0, 3'b100, "mid_nmi2_rise");
    step_until(104);
    mid();

    n_chk++;
    if (tickq.size() != 0) begin
      n_fail++;
      $display("FAIL tick_timeout: %0d expected TICKs never seen, expected 0", tickq.size());
    end
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations unchecked, expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
